// File: rtl/gpio_cfg_pkg.sv
// Constants shared by the serial GPIO configuration transmitter and receiver.
package gpio_cfg_pkg;

    localparam int unsigned CTRL_BITS = 13;

    localparam logic [CTRL_BITS-1:0] DEF_BIDIR = 13'h1803;
    localparam logic [CTRL_BITS-1:0] DEF_INPUT = 13'h0403;

    // Bit positions inside one pad configuration word.
    localparam int unsigned OEB     = 1;
    localparam int unsigned INP_DIS = 3;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_CLEAR,
        EV_LOAD,
        EV_SHIFT
    } ser_event_t;

    function automatic int unsigned cfg_width(input int unsigned num_pads,
                                              input int unsigned ctrl_bits);
        return num_pads * ctrl_bits;
    endfunction

endpackage

// File: rtl/gpio_serial_cfg_rx_sync.sv
// Aligned synchronizer for the loader clock/strobe/data, with edge detects
// taken on the synchronized copies.
module serial_in_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic serial_clock,
    input  logic serial_resetn,
    input  logic serial_data_in,
    output logic sclk,
    output logic srstn,
    output logic din,
    output logic sclk_rise,
    output logic srstn_fall
);
    localparam int unsigned DEPTH = (SYNC_STAGES == 0) ? 1 : SYNC_STAGES;
    // Packed as {clock, strobe, data}; idle loader has the strobe high.
    localparam logic [2:0] IDLE = 3'b010;

    logic [2:0] stage [DEPTH];
    logic       sclk_prev;
    logic       srstn_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= IDLE;
            sclk_prev  <= 1'b0;
            srstn_prev <= 1'b1;
        end else begin
            stage[0] <= {serial_clock, serial_resetn, serial_data_in};
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            sclk_prev  <= stage[DEPTH-1][2];
            srstn_prev <= stage[DEPTH-1][1];
        end
    end

    assign {sclk, srstn, din} = stage[DEPTH-1];
    assign sclk_rise  = sclk & ~sclk_prev;
    assign srstn_fall = srstn_prev & ~srstn;

endmodule

// File: rtl/gpio_serial_cfg_rx.sv
// Receiving end of the serial GPIO configuration loader: shifts pad words
// into a chain and commits them to the per-pad registers on a load strobe.
module gpio_serial_cfg_rx
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned           NUM_PADS    = 19,
    parameter int unsigned           CTRL_BITS   = gpio_cfg_pkg::CTRL_BITS,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter int unsigned           BIDIR_PADS  = 2,
    parameter logic [CTRL_BITS-1:0]  DEF_BIDIR   = gpio_cfg_pkg::DEF_BIDIR,
    parameter logic [CTRL_BITS-1:0]  DEF_INPUT   = gpio_cfg_pkg::DEF_INPUT
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          serial_clock,
    input  logic                          serial_resetn,
    input  logic                          serial_data_in,
    output logic [NUM_PADS*CTRL_BITS-1:0] pad_cfg,
    output logic                          serial_data_out,
    output logic                          load_pulse,
    output logic                          frame_err,
    output logic                          busy
);
    localparam int unsigned W  = cfg_width(NUM_PADS, CTRL_BITS);
    localparam int unsigned CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] FULL    = CW'(W);

    function automatic logic [W-1:0] reset_cfg();
        logic [W-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_PADS; k++)
            v[k*CTRL_BITS +: CTRL_BITS] = (k < BIDIR_PADS) ? DEF_BIDIR : DEF_INPUT;
        return v;
    endfunction

    localparam logic [W-1:0] RESET_CFG = reset_cfg();

    logic          sclk, srstn, din, sclk_rise, srstn_fall;
    logic [W-1:0]  sr;
    logic [CW-1:0] bit_count;
    ser_event_t    ev;

    serial_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk            (clk),
        .resetn         (resetn),
        .serial_clock   (serial_clock),
        .serial_resetn  (serial_resetn),
        .serial_data_in (serial_data_in),
        .sclk           (sclk),
        .srstn          (srstn),
        .din            (din),
        .sclk_rise      (sclk_rise),
        .srstn_fall     (srstn_fall)
    );

    // LOAD outranks SHIFT so a strobe fall coinciding with a clock rise never shifts.
    always_comb begin
        ev = EV_NONE;
        if (!srstn && !sclk)
            ev = EV_CLEAR;
        else if (srstn_fall && sclk)
            ev = EV_LOAD;
        else if (sclk_rise && srstn)
            ev = EV_SHIFT;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr         <= '0;
            bit_count  <= '0;
            pad_cfg    <= RESET_CFG;
            load_pulse <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            case (ev)
                EV_CLEAR: begin
                    sr        <= '0;
                    bit_count <= '0;
                end
                EV_LOAD: begin
                    bit_count <= '0;
                    if (bit_count == FULL) begin
                        pad_cfg    <= sr;
                        load_pulse <= 1'b1;
                        frame_err  <= 1'b0;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end
                EV_SHIFT: begin
                    sr <= {sr[W-2:0], din};
                    if (bit_count != CNT_MAX) bit_count <= bit_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign serial_data_out = sr[W-1];
    assign busy            = (bit_count != '0);

endmodule

// File: tb/tb_gpio_serial_cfg_rx.sv
// Randomized bench for gpio_serial_cfg_rx against a frame-level model of the loader.
module tb_gpio_serial_cfg_rx;
    localparam int NP   = 19;
    localparam int CB   = 13;
    localparam int W    = NP * CB;
    localparam int SYNC = 2;
    localparam int PH   = SYNC + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          serial_clock = 1'b0;
    logic          serial_resetn = 1'b1;
    logic          serial_data_in = 1'b0;
    logic [W-1:0]  pad_cfg;
    logic          serial_data_out;
    logic          load_pulse;
    logic          frame_err;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int pulse_total = 0;

    logic [CB-1:0] exp_cfg [NP];
    logic          exp_err;
    bit            frame_bits[$];

    gpio_serial_cfg_rx #(
        .NUM_PADS    (NP),
        .CTRL_BITS   (CB),
        .SYNC_STAGES (SYNC),
        .BIDIR_PADS  (2),
        .DEF_BIDIR   (13'h1803),
        .DEF_INPUT   (13'h0403)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .serial_clock    (serial_clock),
        .serial_resetn   (serial_resetn),
        .serial_data_in  (serial_data_in),
        .pad_cfg         (pad_cfg),
        .serial_data_out (serial_data_out),
        .load_pulse      (load_pulse),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load_pulse) pulse_total++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int k = 0; k < NP; k++) exp_cfg[k] = (k < 2) ? 13'h1803 : 13'h0403;
        exp_err = 1'b0;
        frame_bits.delete();
    endfunction

    // Frame is accepted only if exactly NP*CB bits arrived since the last clear/load;
    // the first word sent belongs to the highest pad.
    function automatic bit model_load();
        bit ok;
        logic [CB-1:0] w;
        ok = (frame_bits.size() == W);
        if (ok) begin
            for (int j = 0; j < NP; j++) begin
                w = '0;
                for (int b = 0; b < CB; b++) w = {w[CB-2:0], frame_bits[j*CB + b]};
                exp_cfg[NP-1-j] = w;
            end
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        frame_bits.delete();
        return ok;
    endfunction

    function automatic logic [W-1:0] exp_vec();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < NP; k++) v[k*CB +: CB] = exp_cfg[k];
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b);
        serial_data_in = b;
        serial_clock   = 1'b0;
        wait_clks(PH);
        serial_clock   = 1'b1;
        wait_clks(PH);
        frame_bits.push_back(b);
    endtask

    task automatic send_word(input logic [CB-1:0] w);
        for (int b = CB - 1; b >= 0; b--) send_bit(w[b]);
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    // Strobe low with clock high, then clock low (which also clears the chain), then strobe high.
    // with_rise drives a clock rise in the same sample as the strobe fall.
    task automatic do_load(input bit with_rise, output int lat, output int pulses, output bit ok);
        int p0;
        p0 = pulse_total;
        if (with_rise) begin
            serial_clock = 1'b0;
            serial_data_in = 1'($urandom_range(0, 1));
            wait_clks(PH);
            serial_clock = 1'b1;
        end
        serial_resetn = 1'b0;
        lat = 0;
        for (int i = 1; i <= PH + 2; i++) begin
            @(negedge clk);
            if (load_pulse && lat == 0) lat = i;
        end
        serial_clock = 1'b0;
        wait_clks(PH);
        serial_resetn = 1'b1;
        wait_clks(PH);
        pulses = pulse_total - p0;
        ok = model_load();
    endtask

    task automatic do_clear();
        serial_clock = 1'b0;
        wait_clks(PH);
        serial_resetn = 1'b0;
        wait_clks(PH);
        serial_resetn = 1'b1;
        wait_clks(PH);
        frame_bits.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        wait_clks(2);
        resetn = 1'b1;
        wait_clks(2);
        model_reset();
        checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL reset_pad_cfg got=%h exp=%h", pad_cfg, exp_vec()); end
        checks++; if (pad_cfg[12:0] !== 13'h1803) begin failures++; $display("FAIL reset_pad0 got=%h exp=1803", pad_cfg[12:0]); end
        checks++; if (pad_cfg[38:26] !== 13'h0403) begin failures++; $display("FAIL reset_pad2 got=%h exp=0403", pad_cfg[38:26]); end
        checks++; if ({load_pulse, frame_err, busy, serial_data_out} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {load_pulse, frame_err, busy, serial_data_out});
        end
    endtask

    task automatic test_full_transfer();
        int lat, pulses; bit ok;
        for (int p = NP - 1; p >= 0; p--) send_word(CB'(p + 1));
        do_load(1'b0, lat, pulses, ok);
        checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL full_pad_cfg got=%h exp=%h", pad_cfg, exp_vec()); end
        checks++; if (pad_cfg[18*CB +: CB] !== 13'h0013) begin failures++; $display("FAIL full_pad18 got=%h exp=0013", pad_cfg[18*CB +: CB]); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL full_pulses got=%0d exp=1", pulses); end
        checks++; if (lat !== PH) begin failures++; $display("FAIL full_latency got=%0d exp=%0d", lat, PH); end
        checks++; if (frame_err !== exp_err) begin failures++; $display("FAIL full_frame_err got=%b exp=%b", frame_err, exp_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy got=%b exp=0", busy); end
    endtask

    task automatic test_short_frame();
        int lat, pulses; bit ok;
        send_random(W - 1);
        do_load(1'b0, lat, pulses, ok);
        checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL short_pad_cfg got=%h exp=%h", pad_cfg, exp_vec()); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL short_frame_err got=%b exp=1", frame_err); end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL short_pulses got=%0d exp=0", pulses); end
        send_random(W);
        do_load(1'b0, lat, pulses, ok);
        checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL short_reload_pad_cfg got=%h exp=%h", pad_cfg, exp_vec()); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL short_reload_frame_err got=%b exp=0", frame_err); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL short_reload_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_clear_mid_frame();
        int lat, pulses; bit ok;
        send_random(100);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_busy_before got=%b exp=1", busy); end
        do_clear();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy_after got=%b exp=0", busy); end
        send_random(W);
        do_load(1'b0, lat, pulses, ok);
        checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL clear_pad_cfg got=%h exp=%h", pad_cfg, exp_vec()); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL clear_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_cascade();
        bit sent[$];
        bit b, exp_out;
        do_clear();
        for (int n = 0; n < 260; n++) begin
            b = (n < 130) ? bit'(n % 2 == 0) : 1'($urandom_range(0, 1));
            sent.push_back(b);
            send_bit(b);
            exp_out = (n >= W - 1) ? sent[n - (W - 1)] : 1'b0;
            checks++; if (serial_data_out !== exp_out) begin
                failures++; $display("FAIL cascade_out rise=%0d got=%b exp=%b", n + 1, serial_data_out, exp_out);
            end
        end
        do_clear();
    endtask

    task automatic test_simultaneous();
        int lat, pulses; bit ok;
        send_random(W);
        do_load(1'b1, lat, pulses, ok);
        checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL simul_pad_cfg got=%h exp=%h", pad_cfg, exp_vec()); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL simul_pulses got=%0d exp=1", pulses); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL simul_frame_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_random_transfers();
        int lat, pulses; bit ok;
        for (int t = 0; t < 3; t++) begin
            send_random(W);
            do_load(1'b0, lat, pulses, ok);
            checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL rand_pad_cfg t=%0d got=%h exp=%h", t, pad_cfg, exp_vec()); end
            checks++; if (pulses !== 1 || lat !== PH) begin
                failures++; $display("FAIL rand_pulse t=%0d got=%0d/%0d exp=1/%0d", t, pulses, lat, PH);
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        int lat, pulses; bit ok;
        send_random(50);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        serial_clock = 1'b0;
        wait_clks(PH);
        resetn = 1'b0;
        #1;
        model_reset();
        checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL midrst_pad_cfg got=%h exp=%h", pad_cfg, exp_vec()); end
        checks++; if ({load_pulse, frame_err, busy} !== 3'b000) begin
            failures++; $display("FAIL midrst_flags got=%b exp=000", {load_pulse, frame_err, busy});
        end
        wait_clks(2);
        resetn = 1'b1;
        wait_clks(2);
        send_random(W);
        do_load(1'b0, lat, pulses, ok);
        checks++; if (pad_cfg !== exp_vec()) begin failures++; $display("FAIL midrst_reload got=%h exp=%h", pad_cfg, exp_vec()); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL midrst_pulses got=%0d exp=1", pulses); end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_full_transfer();
        test_short_frame();
        test_clear_mid_frame();
        test_cascade();
        test_simultaneous();
        test_random_transfers();
        test_reset_mid_transfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
